// File: rtl/mm_pkg.sv
// mm_pkg: shared constants and FSM state type for the oversampling UART receiver.
// Build macro MM_RX_PARITY_EN adds the PARITY state.
package mm_pkg;

  localparam int OVERSAMPLE       = 16;   // ticks per bit
  localparam int START_MID        = 8;    // ticks from start edge to mid start bit
  localparam int BAUD_DIV_DEFAULT = 326;  // 50 MHz / (9600 * 16)

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
`ifdef MM_RX_PARITY_EN
    , ST_PARITY  = 3'd5
`endif
  } rx_state_e;

endpackage

// File: rtl/uart_rx_os_if.sv
// uart_rx_os_if: byte output channel of the UART receiver plus status pulses.
// Build macro MM_RX_PARITY_EN adds the parity_err pulse.
//
// Handshake: a byte transfers on every rising clk edge where valid && ready.
// The receiver holds data stable while valid is high and never withdraws
// valid before the transfer; the consumer may drive ready at any time.
interface uart_rx_os_if;
  import mm_pkg::*;

  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef MM_RX_PARITY_EN
  logic       parity_err;
`endif
  rx_state_e  state_dbg;

`ifdef MM_RX_PARITY_EN
  modport master (input ready, output data, valid, frame_err, overrun, busy, parity_err, state_dbg);
  modport slave  (output ready, input data, valid, frame_err, overrun, busy, parity_err, state_dbg);
`else
  modport master (input ready, output data, valid, frame_err, overrun, busy, state_dbg);
  modport slave  (output ready, input data, valid, frame_err, overrun, busy, state_dbg);
`endif

endinterface

// File: rtl/uart_rx_os_baud_tick_gen.sv
// baud_tick_gen: one-clk tick every BAUD_DIV clks; clear restarts the period
// so the first tick lands BAUD_DIV clks after the clear.
module baud_tick_gen #(
  parameter int BAUD_DIV = mm_pkg::BAUD_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int             CW   = $clog2(BAUD_DIV);
  localparam logic [CW-1:0]  LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running divider, restarted by clear or reset.
  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x oversampling UART receiver (8 data bits LSB first, 1 stop bit)
// with a one-byte holding register on a valid/ready channel.
// Build macro MM_RX_PARITY_EN adds an even-parity bit and the parity_err pulse.
module uart_rx_os
  import mm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx,
  uart_rx_os_if.master bus
);

  localparam logic [3:0] OS_LAST  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_LAST = 4'(START_MID - 1);

  rx_state_e  state, state_nx;
  logic       rx_s1, rx_s2, rx_d;
  logic [1:0] fill;
  logic       start_det, tick, tick_clr;
  logic [3:0] os_cnt, os_nx;
  logic [2:0] bit_cnt, bit_nx;
  logic [7:0] shreg;
  logic       shift_en, deliver, fe_set;
`ifdef MM_RX_PARITY_EN
  logic       pe_set, par_bad;
`endif

  // Synchronize rx; rx_d remembers a genuinely observed high level so the
  // reset value of the synchronizer can never fake a start edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b0;
      fill  <= 2'b00;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      fill  <= {fill[0], 1'b1};
      rx_d  <= fill[1] & rx_s2;
    end
  end

  assign start_det = rx_d & ~rx_s2;

  baud_tick_gen #(.BAUD_DIV(BAUD_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (tick_clr),
    .tick  (tick)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // Next state, tick/bit counting and sample strobes.
  always_comb begin
    state_nx = state;
    os_nx    = os_cnt;
    bit_nx   = bit_cnt;
    tick_clr = 1'b0;
    shift_en = 1'b0;
    deliver  = 1'b0;
    fe_set   = 1'b0;
`ifdef MM_RX_PARITY_EN
    pe_set   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (start_det) begin
          state_nx = ST_START;
          os_nx    = '0;
          tick_clr = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          if (os_cnt == MID_LAST) begin
            os_nx    = '0;
            bit_nx   = '0;
            state_nx = rx_s2 ? ST_IDLE : ST_DATA;
          end else begin
            os_nx = os_cnt + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (os_cnt == OS_LAST) begin
            os_nx    = '0;
            shift_en = 1'b1;
            bit_nx   = bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
`ifdef MM_RX_PARITY_EN
              state_nx = ST_PARITY;
`else
              state_nx = ST_STOP;
`endif
            end
          end else begin
            os_nx = os_cnt + 1'b1;
          end
        end
      end
`ifdef MM_RX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          if (os_cnt == OS_LAST) begin
            os_nx    = '0;
            pe_set   = (rx_s2 != ^shreg);
            state_nx = ST_STOP;
          end else begin
            os_nx = os_cnt + 1'b1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (os_cnt == OS_LAST) begin
            os_nx = '0;
            if (rx_s2) begin
`ifdef MM_RX_PARITY_EN
              deliver = !par_bad;
`else
              deliver = 1'b1;
`endif
              state_nx = ST_IDLE;
            end else begin
              fe_set   = 1'b1;
              state_nx = ST_WAIT_HIGH;
            end
          end else begin
            os_nx = os_cnt + 1'b1;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s2) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Counters and the LSB-first shift register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      os_cnt  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      os_cnt  <= os_nx;
      bit_cnt <= bit_nx;
      if (shift_en) shreg <= {rx_s2, shreg[7:1]};
    end
  end

`ifdef MM_RX_PARITY_EN
  // Parity result is held until the stop sample decides delivery.
  always_ff @(posedge clk) begin
    if (!rst) begin
      par_bad        <= 1'b0;
      bus.parity_err <= 1'b0;
    end else begin
      bus.parity_err <= pe_set;
      if (state == ST_IDLE) par_bad <= 1'b0;
      else if (pe_set)      par_bad <= 1'b1;
    end
  end
`endif

  // Holding register: accept a new byte when empty or being drained this edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.data      <= '0;
      bus.valid     <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      bus.frame_err <= fe_set;
      bus.overrun   <= 1'b0;
      if (deliver) begin
        if (!bus.valid || bus.ready) begin
          bus.data  <= shreg;
          bus.valid <= 1'b1;
        end else begin
          bus.overrun <= 1'b1;
        end
      end else if (bus.valid && bus.ready) begin
        bus.valid <= 1'b0;
      end
    end
  end

  assign bus.busy      = (state != ST_IDLE);
  assign bus.state_dbg = state;

endmodule

// File: doc/uart_rx_os.md
UART_RX_OS -- requirements
Module: uart_rx_os

Interface
REQ-001 Parameter: BAUD_DIV, default 326, clk cycles per 1/16-bit tick (50 MHz, 9600 baud); legal range 2..65535.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 rx  input  1  asynchronous serial line, idle high, 8 data bits LSB first, 1 stop bit.
REQ-005 ready  input  1  consumer (matrix loader) accepts byte when ready&&valid.
REQ-006 data  output  8  received byte, stable while valid=1.
REQ-007 valid  output  1  byte available in holding register.
REQ-008 frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-009 overrun  output  1  one-clk pulse: byte completed while holding register full and not drained.
REQ-010 busy  output  1  high in every state except IDLE.

Function
REQ-011 rx SHALL pass a 2-flop synchronizer (both flops reset to 1); only the synchronized value is used.
REQ-012 Tick generator SHALL pulse one clk every BAUD_DIV clks; counter SHALL clear on the start-edge detect so sampling is phase-aligned to the frame.
REQ-013 FSM states: IDLE, START, DATA, STOP, WAIT_HIGH (plus PARITY when MM_RX_PARITY_EN).
REQ-014 IDLE -> START on synchronized rx 1->0 transition.
REQ-015 START: after 8 ticks resample; rx=0 -> DATA, rx=1 -> IDLE (glitch rejected, no output, no flags).
REQ-016 DATA: sample every 16 ticks, shift into bit[0..7] LSB first; after 8th sample -> STOP (or PARITY).
REQ-017 STOP: sample after 16 ticks; rx=1 -> byte delivered, -> IDLE; rx=0 -> frame_err pulse, byte discarded, -> WAIT_HIGH.
REQ-018 WAIT_HIGH -> IDLE on first clk with synchronized rx=1 (break conditions produce a single frame_err).
REQ-019 Delivery: data/valid registered on the clk edge that evaluates the stop sample; valid visible next cycle.
REQ-020 valid SHALL drop the cycle after ready&&valid unless a new byte is delivered on that same edge, in which case data updates and valid stays 1.
REQ-021 Delivery while valid=1 and ready=0: new byte dropped, old data retained, overrun pulses one clk.
REQ-022 data SHALL not change while valid=1 except per REQ-020.

Reset
REQ-023 rst=0 at any clk edge, including mid-frame: FSM -> IDLE, tick counter, bit counter, shift register cleared, data=0, valid=0, frame_err=0, overrun=0, busy=0, synchronizer=1.
REQ-024 After rst release a frame already in progress SHALL be ignored until the line is seen high then falls.

Configuration
REQ-025 Macro MM_RX_PARITY_EN defined: PARITY state after DATA samples a 9th bit, even parity; mismatch discards byte, adds output parity_err (1-bit, one-clk pulse), FSM continues to STOP.
REQ-026 Macro undefined: no PARITY state, no parity_err port, 10-bit frame.

Structure
REQ-027 Package mm_pkg SHALL hold the FSM state enum, OVERSAMPLE=16, START_MID=8 and default BAUD_DIV.
REQ-028 One sub-module baud_tick_gen (BAUD_DIV parameter, clear input, tick output); all else in uart_rx_os.

Verification (BAUD_DIV=4, bit = 64 clk)
REQ-029 Frame 0xA5, ready=1 -> data=0xA5, valid high exactly 1 clk, frame_err=0, overrun=0.
REQ-030 rx low pulse 20 clk in IDLE -> no valid, no flags, busy returns 0 within 40 clk.
REQ-031 Frame 0x3C with stop bit 0 then line high -> frame_err one pulse, valid stays 0, next frame 0x81 received correctly.
REQ-032 ready=0, frames 0x11 then 0x22 -> data=0x11 held, overrun pulse at second stop sample; ready=1 -> 0x11 accepted, valid=0.
REQ-033 rst=0 during bit 4 of 0xFF, released mid-frame -> no valid, no frame_err; next frame 0x5A received correctly.
REQ-034 MM_RX_PARITY_EN: 0x07 with parity bit 0 -> parity_err pulse, no valid; parity bit 1 -> data=0x07.
